// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared constants and helpers for updown_counter_param and its prescaler.
//   DIR_UP / DIR_DOWN   : encodings of the count_dir input
//   MODE_WRAP / MODE_SAT: encodings of the sat_mode input
//   prescale_width()    : bit width needed to hold 0..PRESCALE-1 (min 1)
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // ceil(log2(p)), never less than 1 so a PRESCALE of 1 still gets a real flop
  function automatic int prescale_width(input int p);
    int w;
    w = 1;
    while ((1 << w) < p) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// ---------------------------------------------------------------------------
// counter_prescaler
// Divides the run cycles of the counter by PRESCALE.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, phase returns to 0
//   hold  : freeze the phase
//   clear : return the phase to 0 (used on load)
//   tick  : high on the run cycle in which the phase is PRESCALE-1
// Priority: rst > clear > hold > count.
// ---------------------------------------------------------------------------
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic clear,
  output logic tick
);

  localparam int PS_W = prescale_width(PRESCALE);
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] phase_q;
  logic [PS_W-1:0] phase_d;
  logic            at_last_s;

  assign at_last_s = (phase_q == LAST);

  // tick is only meaningful on a running cycle; the top also gates it with load
  assign tick = at_last_s && !hold;

  // next phase: freeze on hold, restart on clear, wrap after the last phase
  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (hold) begin
      phase_d = phase_q;
    end else if (at_last_s) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PS_W'(1);
    end
  end

  // phase register
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// ---------------------------------------------------------------------------
// updown_counter_param
// Parametrised up/down event/timebase counter with runtime limit, wrap or
// saturate behaviour, synchronous load and a clock prescaler.
// Optional feature macro: COUNTER_STICKY_FLAGS_EN (adds flag_clr input and
// ovf_sticky / unf_sticky outputs).
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   hold       : freeze count and prescaler
//   count_dir  : 1 up, 0 down
//   sat_mode   : 1 saturate, 0 wrap
//   load       : synchronous load of load_value
//   load_value : value taken on load
//   limit      : inclusive upper boundary
//   count_out  : registered count
//   tc         : one-cycle pulse after a boundary tick
//   at_zero    : count_out == 0
//   at_limit   : count_out >= limit
// Priority per edge: rst > load > hold > advance.
// ---------------------------------------------------------------------------
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PRESCALE  = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             count_dir,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
`ifdef COUNTER_STICKY_FLAGS_EN
  input  logic             flag_clr,
  output logic             ovf_sticky,
  output logic             unf_sticky,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             at_zero,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             tick_s;
  logic             up_hit_s;
  logic             dn_hit_s;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .hold  (hold),
    .clear (load),
    .tick  (tick_s)
  );

  // next count and boundary detection
  always_comb begin
    count_d  = count_q;
    tc_d     = 1'b0;
    up_hit_s = 1'b0;
    dn_hit_s = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (hold) begin
      // value frozen; tc drops because no boundary tick happens here
      count_d = count_q;
    end else if (tick_s) begin
      if (count_dir == DIR_UP) begin
        if (count_q < limit) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          count_d  = (sat_mode == MODE_SAT) ? limit : '0;
          up_hit_s = 1'b1;
        end
      end else begin
        if (count_q > limit) begin
          // above the window: not a boundary, just re-enter or step down
          count_d = (sat_mode == MODE_SAT) ? limit : (count_q - WIDTH'(1));
        end else if (count_q == '0) begin
          count_d  = (sat_mode == MODE_SAT) ? '0 : limit;
          dn_hit_s = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      tc_d = up_hit_s || dn_hit_s;
    end else begin
      count_d = count_q;
    end
  end

  // count and terminal-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_COUNT;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

`ifdef COUNTER_STICKY_FLAGS_EN
  logic ovf_q;
  logic ovf_d;
  logic unf_q;
  logic unf_d;

  // sticky flags: a set in the same cycle as flag_clr wins
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (up_hit_s) begin
      ovf_d = 1'b1;
    end else if (flag_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (dn_hit_s) begin
      unf_d = 1'b1;
    end else if (flag_clr) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // sticky flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;
`endif

  assign count_out = count_q;
  assign tc        = tc_q;
  assign at_zero   = (count_q == '0);
  assign at_limit  = (count_q >= limit);

endmodule
